// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV-style multiply/divide unit (shift-add / restoring divide).
// Optional feature macro: MULDIV_FAST_MUL_EN -- single-cycle multiplies; divides stay iterative.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             bypass_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] result_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Accept-side decode
  logic             signed_a, signed_b, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, fast_mul;
  logic             neg_d, bypass_d;
  logic [WIDTH-1:0] bypass_val;
`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0]    prod_fast, prod_fast_s;
`endif

  // Operand signs/magnitudes and single-cycle special results
  always_comb begin
    signed_a   = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    signed_b   = op[2] ? ~op[0] : ~op[1];
    sa         = signed_a & a[WIDTH-1];
    sb         = signed_b & b[WIDTH-1];
    mag_a      = sa ? (~a + WIDTH'(1)) : a;
    mag_b      = sb ? (~b + WIDTH'(1)) : b;
    neg_d      = (op[2] & op[1]) ? sa : (sa ^ sb);
    div_zero   = op[2] && (b == '0);
    div_ovf    = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    fast_mul   = 1'b0;
    bypass_val = '0;
    if (div_zero) begin
      bypass_val = op[1] ? a : '1;
    end else if (div_ovf) begin
      bypass_val = op[1] ? '0 : a;
    end
`ifdef MULDIV_FAST_MUL_EN
    prod_fast   = PW'(mag_a) * PW'(mag_b);
    prod_fast_s = neg_d ? (~prod_fast + PW'(1)) : prod_fast;
    if (!op[2]) begin
      fast_mul   = 1'b1;
      bypass_val = (op[1:0] == 2'b00) ? prod_fast_s[WIDTH-1:0] : prod_fast_s[PW-1:WIDTH];
    end
`endif
    bypass_d = div_zero | div_ovf | fast_mul;
  end

  // Iteration step and final result formatting
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [PW-1:0]    prod, prod_s;
  logic [WIDTH-1:0] mul_res, div_res, final_val;

  // One shift-add or restoring shift-subtract step on the shared hi/lo registers
  always_comb begin
    addend  = lo_q[0] ? opnd_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_q});
    if (op_q[2]) begin
      hi_d = ge ? WIDTH'(shifted - {1'b0, opnd_q}) : shifted[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
    prod    = {hi_d, lo_d};
    prod_s  = neg_q ? (~prod + PW'(1)) : prod;
    mul_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[PW-1:WIDTH];
    if (op_q[1]) begin
      div_res = neg_q ? (~hi_d + WIDTH'(1)) : hi_d;
    end else begin
      div_res = neg_q ? (~lo_d + WIDTH'(1)) : lo_d;
    end
    if (bypass_q) begin
      final_val = hi_q;
    end else begin
      final_val = op_q[2] ? div_res : mul_res;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      bypass_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            neg_q      <= neg_d;
            bypass_q   <= bypass_d;
            hi_q       <= bypass_d ? bypass_val : '0;
            lo_q       <= mag_a;
            opnd_q     <= mag_b;
            cnt_q      <= bypass_d ? CW'(1) : CW'(WIDTH);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q    <= final_val;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Reference result from plain integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          ix, iy;
    logic [63:0] p;
    ix = x;
    iy = y;
    case (o)
      3'b000: begin p = longint'(ix) * longint'(iy); return p[31:0]; end
      3'b001: begin p = longint'(ix) * longint'(iy); return p[63:32]; end
      3'b010: begin p = longint'(ix) * {32'b0, y}; return p[63:32]; end
      3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(ix / iy);
      end
      3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ix % iy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Edges from accept until out_valid is seen
  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return FAST ? 1 : 32;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for result, optional hold/pulse, release
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit hold, input bit pulse);
    int          n;
    logic [31:0] exp_r;
    exp_r = ref_model(o, x, y);
    @(negedge clk);
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = pulse && (n == 5);
    end while (!out_valid && n < 100);
    in_valid = 1'b0;
    chk({tag, "/latency"}, 32'(n), 32'(exp_lat(o, x, y)));
    chk({tag, "/result"}, result, exp_r);
    if (hold) begin
      repeat (5) begin
        @(negedge clk);
        chk({tag, "/hold_result"}, result, exp_r);
        chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "/hold_out_valid"}, 32'(out_valid), 32'd1);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "/release_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          seen;
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #1;
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset/in_ready", 32'(in_ready), 32'd1);

    run_op("mul_neg",     3'b000, 32'd7,         32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("mulhsu",      3'b010, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0);
    run_op("div_neg",     3'b100, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op("rem_neg",     3'b110, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op("divu",        3'b101, 32'd100,       32'd7,         1'b0, 1'b0);
    run_op("remu",        3'b111, 32'd100,       32'd7,         1'b0, 1'b0);
    run_op("div_zero",    3'b100, 32'd5,         32'd0,         1'b0, 1'b0);
    run_op("rem_zero",    3'b110, 32'd5,         32'd0,         1'b0, 1'b0);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("hold_pulse",  3'b101, 32'd1000,      32'd9,         1'b1, 1'b1);

    // Reset with counter at 10 discards the in-flight divide
    @(negedge clk);
    in_valid = 1'b1; op = 3'b101; a = 32'd12345; b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (22) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset/out_valid", 32'(out_valid), 32'd0);
    chk("midreset/result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset/in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset/no_result", 32'(seen), 32'd0);
    run_op("post_reset_divu", 3'b101, 32'd9, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 15));
        3: rx = 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", ro, rx, ry, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port a  input  WIDTH  operand A (rs1).
REQ-008 SHALL have port b  input  WIDTH  operand B (rs2).
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  operation result.

Function
REQ-012 SHALL implement FSM IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 Accept SHALL occur on an edge with in_valid&&in_ready; op, |a|, |b|, result signs latched; IDLE->CALC, iteration counter=WIDTH.
REQ-014 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per edge; counter decrements; on final step -> DONE.
REQ-015 Normal-path latency: accept at edge t0 -> out_valid high after edge t0+WIDTH.
REQ-016 Sign rules: MUL/MULH signed x signed; MULHSU signed a x unsigned b; MULHU unsigned; DIV/REM signed; DIVU/REMU unsigned.
REQ-017 MUL SHALL return low WIDTH bits of 2*WIDTH product; MULH/MULHSU/MULHU return high WIDTH bits.
REQ-018 DIV SHALL truncate toward zero; REM takes sign of dividend a.
REQ-019 Divide by zero (b==0): quotient all ones, remainder = a; detected at accept, CALC skipped, out_valid after edge t0+1.
REQ-020 Signed overflow (DIV/REM, a = most-negative, b = all ones): quotient = a, remainder = 0; same 1-cycle path as REQ-019.
REQ-021 In DONE, result SHALL stay stable until out_ready=1; on that edge DONE->IDLE; no request accepted on the same edge.
REQ-022 in_valid, op, a, b SHALL be ignored while in CALC or DONE.
REQ-023 Result SHALL be registered; no combinational path from a, b or op to result.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, counter 0, result 0, out_valid 0; in_ready 1 once rst_n is deasserted.
REQ-025 Reset during CALC or DONE SHALL discard the in-flight operation; no result is ever delivered for it.

Configuration
REQ-026 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU SHALL compute in a single cycle (out_valid after edge t0+1); division unchanged.
REQ-027 Macro MULDIV_FAST_MUL_EN undefined: all multiplies SHALL be iterative per REQ-014/REQ-015; no WIDTH x WIDTH multiplier instantiated.

Verification (WIDTH=32)
REQ-028 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid after 32 edges (1 edge with MULDIV_FAST_MUL_EN).
REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each out_valid after 32 edges.
REQ-031 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; each out_valid after 1 edge.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> result constant, in_ready=0; pulse in_valid with new operands during CALC -> ignored, first result unchanged.
REQ-033 Drop rst_n mid-CALC (counter=10) -> out_valid 0 and result 0 immediately; after release in_ready=1; next DIVU 9/3 -> 3.
